// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding and sizing helpers for the systolic GEMM core.
// Revision 1.0
`default_nettype none

package sa_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Cycles needed after the last accepted beat for it to reach PE(N-1,N-1).
    function automatic int drain_cyc(input int n);
        return 2 * n - 1;
    endfunction

    // Width of a counter able to hold values 0..maxval inclusive.
    function automatic int cnt_w(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sa_gemm_core_if.sv
// sa_gemm_core_if: job control, operand stream and result readout bundle.
// Revision 1.0
`default_nettype none

interface sa_gemm_core_if
    import sa_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int ACC_W = 32,
    parameter int KMAX  = 256
);
    localparam int KW = cnt_w(KMAX);
    localparam int AW = $clog2(N * N);

    logic              start;
    logic [KW-1:0]     k_len;
    logic              signed_mode;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   a_col;
    logic [N*DW-1:0]   b_row;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [ACC_W-1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output start, k_len, signed_mode, in_valid, a_col, b_row, rd_en, rd_addr,
        input  in_ready, busy, done, rd_data, rd_valid
    );

    modport slave (
        input  start, k_len, signed_mode, in_valid, a_col, b_row, rd_en, rd_addr,
        output in_ready, busy, done, rd_data, rd_valid
    );

endinterface

`default_nettype wire

// File: rtl/sa_pe.sv
// sa_pe: valid-gated multiply-accumulate cell with registered a/b/valid forwarding.
// Revision 1.0
`default_nettype none

module sa_pe
    import sa_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_signed,
    input  wire logic [DW-1:0]    i_a,
    input  wire logic             i_a_vld,
    input  wire logic [DW-1:0]    i_b,
    input  wire logic             i_b_vld,
    output logic      [DW-1:0]    o_a,
    output logic                  o_a_vld,
    output logic      [DW-1:0]    o_b,
    output logic                  o_b_vld,
    output logic      [ACC_W-1:0] o_acc
);

    logic signed [2*DW-1:0] w_sprod;
    logic        [2*DW-1:0] w_uprod;
    logic        [ACC_W-1:0] w_ext;

    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic             r_a_vld;
    logic             r_b_vld;
    logic [ACC_W-1:0] r_acc;

    // Operands widened up front so the product is exactly 2*DW bits in either mode.
    assign w_sprod = $signed({{DW{i_a[DW-1]}}, i_a}) * $signed({{DW{i_b[DW-1]}}, i_b});
    assign w_uprod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
    assign w_ext   = i_signed ? ACC_W'(w_sprod) : ACC_W'(w_uprod);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_vld <= 1'b0;
            r_b_vld <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_a_vld <= i_a_vld;
            r_b_vld <= i_b_vld;
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_a_vld && i_b_vld) begin
                r_acc <= r_acc + w_ext;
            end
        end
    end

    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_a_vld = r_a_vld;
    assign o_b_vld = r_b_vld;
    assign o_acc   = r_acc;

endmodule

`default_nettype wire

// File: rtl/sa_gemm_core.sv
// sa_gemm_core: N x N output-stationary systolic GEMM with input skew and result readout.
// Revision 1.0
`default_nettype none

module sa_gemm_core
    import sa_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int ACC_W = 32,
    parameter int KMAX  = 256
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sa_gemm_core_if.slave  bus
);

    localparam int c_KW    = cnt_w(KMAX);
    localparam int c_DRAIN = drain_cyc(N);
    localparam int c_DCW   = cnt_w(c_DRAIN);

    state_t r_state;
    state_t w_state_nxt;

    logic [c_KW-1:0]  r_k_len;
    logic [c_KW-1:0]  r_beat_cnt;
    logic [c_DCW-1:0] r_drn_cnt;
    logic             r_signed;
    logic             r_busy;
    logic             r_done;
    logic             r_in_ready;
    logic [ACC_W-1:0] r_rd_data;
    logic             r_rd_valid;

    logic w_start_acc;
    logic w_beat;
    logic w_last;

    logic [DW-1:0]    w_a_h  [N][N+1];
    logic             w_av_h [N][N+1];
    logic [DW-1:0]    w_b_v  [N+1][N];
    logic             w_bv_v [N+1][N];
    logic [ACC_W-1:0] w_acc  [N*N];
    logic [N-1:0]     w_unused_edge;

    assign w_start_acc = (r_state == S_IDLE) && bus.start;
    assign w_beat      = (r_state == S_LOAD) && bus.in_valid && r_in_ready;
    assign w_last      = w_beat && (r_beat_cnt == r_k_len - c_KW'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = (bus.k_len == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drn_cnt == c_DCW'(c_DRAIN - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_k_len    <= '0;
            r_beat_cnt <= '0;
            r_drn_cnt  <= '0;
            r_signed   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_DONE);

            if (w_start_acc) begin
                r_k_len    <= bus.k_len;
                r_signed   <= bus.signed_mode;
                r_beat_cnt <= '0;
                r_busy     <= 1'b1;
                r_in_ready <= (bus.k_len != '0);
            end else begin
                if (r_state == S_DONE) r_busy <= 1'b0;
                if (w_last) r_in_ready <= 1'b0;
                if (w_beat) r_beat_cnt <= r_beat_cnt + c_KW'(1);
            end

            if (w_last) begin
                r_drn_cnt <= '0;
            end else if (r_state == S_DRAIN) begin
                r_drn_cnt <= r_drn_cnt + c_DCW'(1);
            end

            // Non-blocking read sees pre-clear sums when it coincides with a start.
            if (bus.rd_en) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= (int'(bus.rd_addr) < N * N) ? w_acc[bus.rd_addr] : '0;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // Lane i passes through one entry register plus i skew stages.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] r_a_d [0:i];
        logic          r_a_v [0:i];
        logic [DW-1:0] r_b_d [0:i];
        logic          r_b_v [0:i];

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int s = 0; s <= i; s++) begin
                    r_a_d[s] <= '0;
                    r_a_v[s] <= 1'b0;
                    r_b_d[s] <= '0;
                    r_b_v[s] <= 1'b0;
                end
            end else begin
                r_a_d[0] <= bus.a_col[i*DW +: DW];
                r_a_v[0] <= w_beat;
                r_b_d[0] <= bus.b_row[i*DW +: DW];
                r_b_v[0] <= w_beat;
                for (int s = 1; s <= i; s++) begin
                    r_a_d[s] <= r_a_d[s-1];
                    r_a_v[s] <= r_a_v[s-1];
                    r_b_d[s] <= r_b_d[s-1];
                    r_b_v[s] <= r_b_v[s-1];
                end
            end
        end

        assign w_a_h[i][0]  = r_a_d[i];
        assign w_av_h[i][0] = r_a_v[i];
        assign w_b_v[0][i]  = r_b_d[i];
        assign w_bv_v[0][i] = r_b_v[i];
        assign w_unused_edge[i] = ^{w_a_h[i][N], w_av_h[i][N], w_b_v[N][i], w_bv_v[N][i]};
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sa_pe #(
                .DW    (DW),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .i_clr    (w_start_acc),
                .i_signed (r_signed),
                .i_a      (w_a_h[i][j]),
                .i_a_vld  (w_av_h[i][j]),
                .i_b      (w_b_v[i][j]),
                .i_b_vld  (w_bv_v[i][j]),
                .o_a      (w_a_h[i][j+1]),
                .o_a_vld  (w_av_h[i][j+1]),
                .o_b      (w_b_v[i+1][j]),
                .o_b_vld  (w_bv_v[i+1][j]),
                .o_acc    (w_acc[i*N+j])
            );
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: doc/sa_gemm_core.md
Name: sa_gemm_core

Overview:
- Parametrised N×N output-stationary systolic GEMM core.
- Accepts one column of A and one row of B per handshake beat, skews the lanes internally, and accumulates C = A×B over a runtime reduction length k_len.
- Holds the N×N result for random-access readout.
- Next-generation core between the operand memories and the output memory; adds in-core skew, bubble tolerance, a signed/unsigned mode and start/done control.

Parameters:
- N, 4, array dimension (rows = columns = N), N ≥ 2
- DW, 16, operand width in bits
- ACC_W, 32, accumulator width; must be ≥ 2*DW
- KMAX, 256, maximum reduction length

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begins a job; ignored while busy=1
- k_len  in  $clog2(KMAX+1)  reduction length; sampled on accepted start
- signed_mode  in  1  1 = two's-complement operands; sampled on accepted start
- in_valid  in  1  operand beat valid
- in_ready  out  1  core accepts beat
- a_col  in  N*DW  lane i = A[i][k], lane 0 in LSBs
- b_row  in  N*DW  lane j = B[k][j], lane 0 in LSBs
- busy  out  1  job in progress
- done  out  1  one-cycle pulse; job complete
- rd_en  in  1  result read request
- rd_addr  in  $clog2(N*N)  row-major index i*N+j
- rd_data  out  ACC_W  C[i][j]
- rd_valid  out  1  rd_data valid

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; busy, done, in_ready, rd_valid, rd_data all 0; all accumulators, skew registers and counters 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1: clear all accumulators, latch k_len and signed_mode, beat counter=0, busy=1.
  - Next state is LOAD, or DONE if k_len=0.
- LOAD:
  - in_ready=1 (registered).
  - A beat is accepted at an edge where in_valid & in_ready; beat counter +1.
  - On acceptance of beat k_len-1: in_ready falls at that same edge and the next state is DRAIN.
- DRAIN: counts 2N-1 cycles, then DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Latency: the last beat is accepted at edge T; done is high in the cycle after edge T+2N (N=4 → edge T+8). For k_len=0, done is high in the cycle after the second edge following start.
- Skew:
  - Row lane i is delayed i stages; column lane j is delayed j stages.
  - A valid bit travels with every data stage.
  - PE(i,j) accumulates beat k at edge T_k+1+i+j.
  - Cycles with in_valid=0 inject valid=0 bubbles. PEs hold their value on invalid data, so bubbles never alter the result.
- PE datapath:
  - a/b/valid forwarded right/down, one register per hop.
  - acc += ext(a*b). The product is 2*DW bits, then sign- or zero-extended to ACC_W per the latched mode.
  - Accumulation wraps modulo 2^ACC_W; no saturation.
- Readout:
  - rd_en at edge t → rd_data and rd_valid=1 at edge t+1; otherwise rd_valid=0 and rd_data holds.
  - Legal in any state. Reads while busy return live partial sums.
  - Results persist until the next accepted start or reset.
- Boundary and simultaneous events:
  - start while busy: ignored; no state change.
  - start and rd_en in the same IDLE cycle: the read returns the pre-clear value.
  - Reset mid-job: immediate return to IDLE, all results cleared, no done pulse.
  - k_len > KMAX: not supported; the input is 0-masked by width.

Decomposition:
- Package sa_pkg:
  - state enum (IDLE/LOAD/DRAIN/DONE)
  - localparam helpers: DRAIN_CYC = 2N-1, address and counter widths
- Sub-module sa_pe: valid-gated MAC with synchronous clear, signed_mode input, registered a/b/valid pass-through.
- Top level: FSM, skew delay lines, N×N generate grid, read mux.

Test Plan:
1. N=4, A=I, B rows [1..4],[5..8],[9..12],[13..16], k_len=4, beats back-to-back → C[i][j]=4i+j+1; done high in the cycle after edge T_last+8; busy falls with done.
2. A all 0xFFFF, B all 0x0002, k_len=3 → signed_mode=1: every C = 0xFFFFFFFA; signed_mode=0: every C = 0x0005FFFA.
3. Repeat test 1 with in_valid toggling 1,0,1,0… (and stalled several cycles) → identical C; done high in the cycle after edge T_last+8.
4. Unsigned, A=B all 0xFFFF, k_len=2 → every C = 0xFFFC0002 (wrapped); read of addr 15 returns data with rd_valid one cycle after rd_en.
5. k_len=0 → in_ready never 1; done high in the cycle after the second edge following start; all reads return 0 after a prior nonzero job.
6. Reset (rst=0) after 2 of 4 beats → busy=0, in_ready=0, no done, all reads 0; a start pulse during a busy job is ignored and the result equals a single-job result.
